// File: rtl/timer_count_core.sv
// Timer counter core: loadable up-counter with compare match, wrap status,
// debug halt handling and a masked interrupt line.
module timer_count_core #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cnt_en,
    input  logic             timer_en,
    input  logic             halt_req,
    input  logic             dbg_mode,
    input  logic             cnt_wr,
    input  logic [CNT_W-1:0] cnt_wdata,
    input  logic             cmp_wr,
    input  logic [CNT_W-1:0] cmp_wdata,
    input  logic             int_en,
    input  logic             int_clr,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cmp,
    output logic             int_st,
    output logic             ovf_st,
    output logic             tim_int,
    output logic             halt_ack
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic             int_st_q, int_st_d;
    logic             ovf_st_q, ovf_st_d;
    logic             halt_ack_q, halt_ack_d;
    logic             tim_en_q, tim_en_d;

    logic halted_c;
    logic inc_c;
    logic fall_c;
    logic wrap_c;
    logic match_c;

    // Qualified count enable; halt only takes effect in debug mode
    always_comb begin
        halted_c = halt_req & dbg_mode;
        inc_c    = cnt_en & timer_en & ~halted_c;
        fall_c   = tim_en_q & ~timer_en;
        wrap_c   = inc_c & ~cnt_wr & ~fall_c & (cnt_q == ALL_ONES);
        match_c  = (cnt_q == cmp_q);
    end

    // Next-state: register write beats enable-drop clear beats increment
    always_comb begin
        cnt_d      = cnt_q;
        cmp_d      = cmp_q;
        int_st_d   = int_st_q;
        ovf_st_d   = ovf_st_q;
        halt_ack_d = halted_c;
        tim_en_d   = timer_en;

        if (cnt_wr) begin
            cnt_d = cnt_wdata;
        end else if (fall_c) begin
            cnt_d = '0;
        end else if (inc_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (cmp_wr) begin
            cmp_d = cmp_wdata;
        end

        // Status set has priority over the write-1-to-clear pulse
        if (match_c) begin
            int_st_d = 1'b1;
        end else if (int_clr) begin
            int_st_d = 1'b0;
        end

        if (wrap_c) begin
            ovf_st_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_st_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= '0;
            cmp_q      <= ALL_ONES;
            int_st_q   <= 1'b0;
            ovf_st_q   <= 1'b0;
            halt_ack_q <= 1'b0;
            tim_en_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
            int_st_q   <= int_st_d;
            ovf_st_q   <= ovf_st_d;
            halt_ack_q <= halt_ack_d;
            tim_en_q   <= tim_en_d;
        end
    end

    assign cnt      = cnt_q;
    assign cmp      = cmp_q;
    assign int_st   = int_st_q;
    assign ovf_st   = ovf_st_q;
    assign halt_ack = halt_ack_q;
    // Only the interrupt mask reaches the output combinationally
    assign tim_int  = int_st_q & int_en;

endmodule

// File: tb/tb_timer_count_core.sv
// Directed self-checking bench for timer_count_core (64-bit configuration).
module tb_timer_count_core;

    localparam int unsigned CNT_W = 64;

    logic             sys_clk;
    logic             sys_rst_n;
    logic             cnt_en;
    logic             timer_en;
    logic             halt_req;
    logic             dbg_mode;
    logic             cnt_wr;
    logic [CNT_W-1:0] cnt_wdata;
    logic             cmp_wr;
    logic [CNT_W-1:0] cmp_wdata;
    logic             int_en;
    logic             int_clr;
    logic             ovf_clr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cmp;
    logic             int_st;
    logic             ovf_st;
    logic             tim_int;
    logic             halt_ack;

    int unsigned n_pass;
    int unsigned n_chk;

    timer_count_core #(.CNT_W(CNT_W)) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cnt_en    (cnt_en),
        .timer_en  (timer_en),
        .halt_req  (halt_req),
        .dbg_mode  (dbg_mode),
        .cnt_wr    (cnt_wr),
        .cnt_wdata (cnt_wdata),
        .cmp_wr    (cmp_wr),
        .cmp_wdata (cmp_wdata),
        .int_en    (int_en),
        .int_clr   (int_clr),
        .ovf_clr   (ovf_clr),
        .cnt       (cnt),
        .cmp       (cmp),
        .int_st    (int_st),
        .ovf_st    (ovf_st),
        .tim_int   (tim_int),
        .halt_ack  (halt_ack)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_cnt_en();
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_chk     = 0;
        sys_rst_n = 1'b0;
        cnt_en    = 1'b0;
        timer_en  = 1'b0;
        halt_req  = 1'b0;
        dbg_mode  = 1'b0;
        cnt_wr    = 1'b0;
        cnt_wdata = '0;
        cmp_wr    = 1'b0;
        cmp_wdata = '0;
        int_en    = 1'b0;
        int_clr   = 1'b0;
        ovf_clr   = 1'b0;

        #12;
        chk("rst_cnt", cnt, 64'h0);
        chk("rst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_int_st", 64'(int_st), 64'h0);
        chk("rst_ovf_st", 64'(ovf_st), 64'h0);
        chk("rst_halt_ack", 64'(halt_ack), 64'h0);
        chk("rst_tim_int", 64'(tim_int), 64'h0);
        sys_rst_n = 1'b1;
        tick();

        // Compare at 5, tick every 4th cycle
        cmp_wr    = 1'b1;
        cmp_wdata = 64'd5;
        tick();
        cmp_wr    = 1'b0;
        chk("cmp_load", cmp, 64'd5);
        timer_en = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            pulse_cnt_en();
            chk($sformatf("count_%0d", k), cnt, 64'(k));
            if (k == 5) chk("int_st_not_yet", 64'(int_st), 64'h0);
            else repeat (3) tick();
        end
        tick();
        chk("int_st_set", 64'(int_st), 64'h1);
        chk("tim_int_masked", 64'(tim_int), 64'h0);
        int_en = 1'b1;
        #1;
        chk("tim_int_on", 64'(tim_int), 64'h1);

        // Clear blocked while match persists, succeeds once off compare
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        chk("int_clr_blocked", 64'(int_st), 64'h1);
        pulse_cnt_en();
        chk("cnt_off_cmp", cnt, 64'd6);
        chk("int_st_hold", 64'(int_st), 64'h1);
        int_clr = 1'b1;
        tick();
        int_clr = 1'b0;
        chk("int_clr_ok", 64'(int_st), 64'h0);
        chk("tim_int_off", 64'(tim_int), 64'h0);
        int_en = 1'b0;

        // Wrap sets overflow status
        cnt_wr    = 1'b1;
        cnt_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        cnt_wr = 1'b0;
        chk("load_fffe", cnt, 64'hFFFF_FFFF_FFFF_FFFE);
        cnt_en = 1'b1;
        tick();
        chk("cnt_ffff", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_before_wrap", 64'(ovf_st), 64'h0);
        tick();
        cnt_en = 1'b0;
        chk("cnt_wrap", cnt, 64'h0);
        chk("ovf_set", 64'(ovf_st), 64'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(ovf_st), 64'h0);

        // Wrap wins over a simultaneous clear
        cnt_wr    = 1'b1;
        cnt_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        cnt_wr  = 1'b0;
        cnt_en  = 1'b1;
        ovf_clr = 1'b1;
        tick();
        cnt_en  = 1'b0;
        ovf_clr = 1'b0;
        chk("wrap_vs_clr_cnt", cnt, 64'h0);
        chk("wrap_vs_clr_ovf", 64'(ovf_st), 64'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Debug halt: load still works, ticks ignored, resume exactly once
        dbg_mode  = 1'b1;
        halt_req  = 1'b1;
        cnt_wr    = 1'b1;
        cnt_wdata = 64'd7;
        tick();
        cnt_wr = 1'b0;
        chk("load_halted", cnt, 64'd7);
        chk("halt_ack_set", 64'(halt_ack), 64'h1);
        for (int k = 0; k < 10; k++) begin
            pulse_cnt_en();
            tick();
        end
        chk("cnt_frozen", cnt, 64'd7);
        halt_req = 1'b0;
        tick();
        chk("halt_ack_clr", 64'(halt_ack), 64'h0);
        chk("cnt_after_release", cnt, 64'd7);
        pulse_cnt_en();
        chk("cnt_resume", cnt, 64'd8);
        dbg_mode = 1'b0;
        halt_req = 1'b1;
        pulse_cnt_en();
        chk("halt_no_dbg_cnt", cnt, 64'd9);
        chk("halt_no_dbg_ack", 64'(halt_ack), 64'h0);
        halt_req = 1'b0;

        // Enable falling edge clears; a write in that cycle wins
        cnt_wr    = 1'b1;
        cnt_wdata = 64'd3;
        tick();
        cnt_wr = 1'b0;
        timer_en = 1'b0;
        tick();
        chk("fall_clear", cnt, 64'h0);
        timer_en = 1'b1;
        tick();
        timer_en  = 1'b0;
        cnt_wr    = 1'b1;
        cnt_wdata = 64'd9;
        tick();
        cnt_wr = 1'b0;
        chk("fall_vs_wr", cnt, 64'd9);
        pulse_cnt_en();
        chk("disabled_no_inc", cnt, 64'd9);
        timer_en = 1'b1;
        tick();

        // Simultaneous counter and compare write
        cnt_wr    = 1'b1;
        cnt_wdata = 64'h20;
        cmp_wr    = 1'b1;
        cmp_wdata = 64'h20;
        tick();
        cnt_wr = 1'b0;
        cmp_wr = 1'b0;
        chk("dual_wr_cnt", cnt, 64'h20);
        chk("dual_wr_cmp", cmp, 64'h20);
        dbg_mode = 1'b1;
        halt_req = 1'b1;
        tick();
        chk("pre_rst_int_st", 64'(int_st), 64'h1);
        chk("pre_rst_halt_ack", 64'(halt_ack), 64'h1);

        // Asynchronous reset between edges
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_cnt", cnt, 64'h0);
        chk("arst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("arst_int_st", 64'(int_st), 64'h0);
        chk("arst_ovf_st", 64'(ovf_st), 64'h0);
        chk("arst_halt_ack", 64'(halt_ack), 64'h0);
        halt_req = 1'b0;
        dbg_mode = 1'b0;
        tick();
        #3;
        sys_rst_n = 1'b1;
        tick();
        chk("post_rst_idle", cnt, 64'h0);
        pulse_cnt_en();
        chk("post_rst_inc", cnt, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_count_core.md
TIMER_COUNT_CORE -- requirements
Module: timer_count_core

Interface
REQ-001 Parameter CNT_W, default 64, SHALL set the counter and compare width; legal range 8..64.
REQ-002 sys_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 sys_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 cnt_en  input  1  SHALL be the single-cycle count tick from the prescaler/counter-control stage.
REQ-005 timer_en  input  1  SHALL be the timer enable level from the control register.
REQ-006 halt_req  input  1  SHALL be the debug halt request level.
REQ-007 dbg_mode  input  1  SHALL be the debug-mode level that permits halting.
REQ-008 cnt_wr  input  1  SHALL be the one-cycle counter load strobe from the APB register block.
REQ-009 cnt_wdata  input  CNT_W  SHALL be the counter load value, sampled when cnt_wr=1.
REQ-010 cmp_wr  input  1  SHALL be the one-cycle compare load strobe.
REQ-011 cmp_wdata  input  CNT_W  SHALL be the compare load value, sampled when cmp_wr=1.
REQ-012 int_en  input  1  SHALL be the interrupt enable level.
REQ-013 int_clr  input  1  SHALL be the decoded write-1-to-clear pulse for int_st.
REQ-014 ovf_clr  input  1  SHALL be the decoded write-1-to-clear pulse for ovf_st.
REQ-015 cnt  output  CNT_W  SHALL be the registered counter value.
REQ-016 cmp  output  CNT_W  SHALL be the registered compare value.
REQ-017 int_st  output  1  SHALL be the sticky registered compare-match status.
REQ-018 ovf_st  output  1  SHALL be the sticky registered wrap status.
REQ-019 tim_int  output  1  SHALL be the interrupt line, int_st AND int_en, combinational from registers only.
REQ-020 halt_ack  output  1  SHALL be the registered halt acknowledge.

Function
REQ-021 halted SHALL be halt_req AND dbg_mode; halt_ack SHALL equal halted delayed one cycle.
REQ-022 inc SHALL be cnt_en AND timer_en AND NOT halted; halt_req without dbg_mode SHALL NOT stop counting.
REQ-023 A timer_en falling edge SHALL be detected from a registered copy tim_en_d (1 -> 0).
REQ-024 Counter next-value priority, highest first: cnt_wr -> cnt_wdata; falling edge -> 0; inc -> cnt+1 modulo 2^CNT_W; else hold.
REQ-025 When inc=1 and cnt is all ones without cnt_wr or a falling edge, cnt SHALL become 0 and ovf_st SHALL set on the same edge.
REQ-026 cmp SHALL load cmp_wdata on cmp_wr and otherwise hold; cnt and cmp SHALL both update when written in the same cycle.
REQ-027 match SHALL be (cnt == cmp) evaluated on the current register values, independent of timer_en and halt.
REQ-028 int_st SHALL set on the edge after any cycle with match=1; set SHALL win over int_clr in the same cycle.
REQ-029 int_st SHALL clear on int_clr when match=0 and otherwise hold; int_st SHALL stay set while cnt remains equal to cmp.
REQ-030 ovf_st SHALL clear on ovf_clr; a wrap in the same cycle SHALL win.
REQ-031 cnt SHALL freeze while halted even if cnt_en pulses; counting SHALL resume on the first cnt_en after halted falls, with no lost or extra increments.
REQ-032 A cnt_wr while halted SHALL still load cnt.
REQ-033 The block SHALL have no combinational path from any input to any output except the int_en -> tim_int path.

Reset
REQ-034 On sys_rst_n=0 the block SHALL immediately set cnt=0, cmp=all ones, int_st=0, ovf_st=0, halt_ack=0, tim_en_d=0.
REQ-035 Reset asserted mid-count SHALL abort the count with no residual state; after release the first increment SHALL require a new cnt_en with timer_en=1.

Verification
REQ-036 timer_en=1, cmp=5, cnt_en every 4th cycle -> cnt 0..5; int_st=1 the edge after cnt=5; with int_en=1, tim_int=1.
REQ-037 Load cnt=0xFFFF_FFFF_FFFF_FFFE, continuous cnt_en -> cnt ...FFFF then 0; ovf_st=1 on the wrap edge; ovf_clr -> ovf_st=0.
REQ-038 cnt=7, dbg_mode=1, halt_req=1 for 10 cnt_en pulses -> cnt stays 7 and halt_ack=1 from the next cycle; release -> cnt=8 after the next cnt_en.
REQ-039 cnt=3, timer_en 1 -> 0 -> cnt=0 on the next edge; cnt_wr=1 with cnt_wdata=9 in the same cycle -> cnt=9 (write wins).
REQ-040 int_st=1 with cnt==cmp held and int_clr pulsed -> int_st stays 1; after cnt moves off cmp, int_clr -> int_st=0.
REQ-041 sys_rst_n asserted asynchronously between edges at cnt=0x20 -> all outputs at reset values without a clock; cmp=all ones.
